rx_frame_sequencer: RTL and testbench

Frame controller that sits directly behind the 4-bit UART receiver. It consumes the receiver's one-cycle `done` strobe and nibble, and enforces a four-nibble frame: SYNC, OP, A, B. It detects sync and inter-nibble timeout errors and presents each completed frame as one command on a valid/ready interface to the downstream datapath. It is the only consumer of the receiver output and owns all framing decisions.

---
 rtl/rx_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_rx_frame_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer
// Frames the UART receiver's nibble stream into SYNC/OP/A/B commands and hands
// each completed frame downstream over a valid/ready command register. Flags
// sync errors, inter-nibble timeouts and overruns as one-cycle pulses.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_SYNC | idle, hunting for SYNC_NIBBLE; non-sync nibbles flagged
// GET_OP    | sync seen, waiting for the OP nibble
// GET_A     | OP latched, waiting for the A nibble
// GET_B     | A latched, waiting for the B nibble (frame commit)
module rx_frame_sequencer #(
  parameter logic [3:0] SYNC_NIBBLE  = 4'hA,
  parameter int         TIMEOUT_CLKS = 125000,
  parameter int         CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [3:0] rx_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_op,
  output logic [3:0] cmd_a,
  output logic [3:0] cmd_b,
  output logic       busy,
  output logic       err_sync,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_OP    = 2'd1,
    GET_A     = 2'd2,
    GET_B     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  state_t           state;
  logic [3:0]       shadow_op;
  logic [3:0]       shadow_a;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cmd_free;

  // The command register can take a new frame if empty or being drained this cycle.
  assign cmd_free = !cmd_valid || cmd_ready;

  // Busy whenever a frame is in progress.
  assign busy = (state != WAIT_SYNC);

  // Frame FSM, timeout counter, command register and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_SYNC;
      shadow_op   <= '0;
      shadow_a    <= '0;
      tmo_cnt     <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_a       <= '0;
      cmd_b       <= '0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      frame_count <= '0;
    end else begin
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      // Handshake drains the register; a same-edge commit below overrides this.
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      case (state)
        WAIT_SYNC: begin
          tmo_cnt <= '0;
          if (rx_done) begin
            if (rx_data == SYNC_NIBBLE) begin
              state <= GET_OP;
            end else begin
              err_sync <= 1'b1;
            end
          end
        end
        default: begin
          // A nibble arriving on the terminal-count cycle wins over the timeout.
          if (rx_done) begin
            tmo_cnt <= '0;
            case (state)
              GET_OP: begin
                shadow_op <= rx_data;
                state     <= GET_A;
              end
              GET_A: begin
                shadow_a <= rx_data;
                state    <= GET_B;
              end
              default: begin
                state <= WAIT_SYNC;
                if (cmd_free) begin
                  cmd_op      <= shadow_op;
                  cmd_a       <= shadow_a;
                  cmd_b       <= rx_data;
                  cmd_valid   <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                end else begin
                  err_overrun <= 1'b1;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= WAIT_SYNC;
            err_timeout <= 1'b1;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Testbench for rx_frame_sequencer: directed frame scenarios followed by random
// nibble/ready traffic, all checked cycle by cycle against a frame-level model.
module tb_rx_frame_sequencer;

  localparam logic [3:0] SYNC = 4'hA;
  localparam int         TMO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [3:0] rx_data;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic       busy, err_sync, err_timeout, err_overrun;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model state
  bit         m_in_frame;
  logic [3:0] m_nibs[$];
  int         m_idle;
  bit         m_valid;
  logic [3:0] m_op, m_a, m_b;
  logic [7:0] m_fc;
  bit         m_esync, m_etmo, m_eovr;

  rx_frame_sequencer #(
    .SYNC_NIBBLE (SYNC),
    .TIMEOUT_CLKS(TMO),
    .CNT_W       (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .busy       (busy),
    .err_sync   (err_sync),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 0;
    m_nibs.delete();
    m_idle  = 0;
    m_valid = 0;
    m_op = '0; m_a = '0; m_b = '0;
    m_fc = '0;
    m_esync = 0; m_etmo = 0; m_eovr = 0;
  endfunction

  // One rising edge of the model: inputs are what the DUT sampled at that edge.
  function automatic void model_edge(input bit d, input logic [3:0] v, input bit r);
    bit was_valid;
    was_valid = m_valid;
    m_esync = 0; m_etmo = 0; m_eovr = 0;
    if (m_valid && r) m_valid = 0;
    if (!m_in_frame) begin
      if (d) begin
        if (v == SYNC) begin
          m_in_frame = 1;
          m_nibs.delete();
          m_idle = 0;
        end else begin
          m_esync = 1;
        end
      end
    end else if (d) begin
      m_idle = 0;
      m_nibs.push_back(v);
      if (m_nibs.size() == 3) begin
        m_in_frame = 0;
        if (!was_valid || r) begin
          m_op = m_nibs[0]; m_a = m_nibs[1]; m_b = m_nibs[2];
          m_valid = 1;
          m_fc = m_fc + 8'd1;
        end else begin
          m_eovr = 1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_in_frame = 0;
        m_etmo = 1;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, ".valid"}, 32'(cmd_valid), 32'(m_valid));
    check_val({tag, ".op"}, 32'(cmd_op), 32'(m_op));
    check_val({tag, ".a"}, 32'(cmd_a), 32'(m_a));
    check_val({tag, ".b"}, 32'(cmd_b), 32'(m_b));
    check_val({tag, ".fc"}, 32'(frame_count), 32'(m_fc));
    check_val({tag, ".busy"}, 32'(busy), 32'(m_in_frame));
    check_val({tag, ".err_sync"}, 32'(err_sync), 32'(m_esync));
    check_val({tag, ".err_tmo"}, 32'(err_timeout), 32'(m_etmo));
    check_val({tag, ".err_ovr"}, 32'(err_overrun), 32'(m_eovr));
  endtask

  task automatic step(input string tag, input bit d, input logic [3:0] v, input bit r);
    rx_done = d; rx_data = v; cmd_ready = r;
    @(posedge clk);
    model_edge(d, v, r);
    #1;
    compare_all(tag);
  endtask

  task automatic send(input string tag, input logic [3:0] v, input bit r);
    step(tag, 1'b1, v, r);
  endtask

  task automatic idle(input string tag, input int n, input bit r);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 4'h0, r);
  endtask

  task automatic do_reset(input string tag);
    rx_done = 0; rx_data = '0; cmd_ready = 0;
    reset = 1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    rx_done = 0; rx_data = '0; cmd_ready = 0; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 0;

    // Basic frame with ready held high: one-cycle command.
    send("t1", 4'hA, 1); send("t1", 4'h3, 1); send("t1", 4'h5, 1); send("t1", 4'hC, 1);
    check_val("t1.op_const", 32'(cmd_op), 32'h3);
    check_val("t1.b_const", 32'(cmd_b), 32'hC);
    check_val("t1.fc_const", 32'(frame_count), 32'd1);
    idle("t1", 2, 1);

    // Sync error then a good frame.
    send("t2", 4'h7, 1);
    check_val("t2.esync_const", 32'(err_sync), 32'd1);
    send("t2", 4'hA, 0); send("t2", 4'h1, 0); send("t2", 4'h2, 0); send("t2", 4'h3, 0);
    check_val("t2.a_const", 32'(cmd_a), 32'h2);
    idle("t2", 1, 1);

    // Timeout after two nibbles, then recovery.
    send("t3", 4'hA, 1); send("t3", 4'h4, 1);
    idle("t3", TMO - 1, 1);
    check_val("t3.busy_pre", 32'(busy), 32'd1);
    idle("t3", 1, 1);
    check_val("t3.tmo_const", 32'(err_timeout), 32'd1);
    check_val("t3.busy_post", 32'(busy), 32'd0);
    idle("t3", 1, 1);
    send("t3", 4'hA, 1); send("t3", 4'h1, 1); send("t3", 4'h1, 1); send("t3", 4'h1, 1);
    idle("t3", 1, 1);

    // Overrun while a command is held.
    send("t4", 4'hA, 0); send("t4", 4'h1, 0); send("t4", 4'h2, 0); send("t4", 4'h3, 0);
    send("t4", 4'hA, 0); send("t4", 4'h4, 0); send("t4", 4'h5, 0); send("t4", 4'h6, 0);
    check_val("t4.ovr_const", 32'(err_overrun), 32'd1);
    check_val("t4.op_kept", 32'(cmd_op), 32'h1);

    // Commit and handshake on the same edge.
    send("t5", 4'hA, 0); send("t5", 4'h7, 0); send("t5", 4'h8, 0); send("t5", 4'h9, 1);
    check_val("t5.valid_kept", 32'(cmd_valid), 32'd1);
    check_val("t5.b_new", 32'(cmd_b), 32'h9);

    // Reset mid-frame with a command held, then stray nibbles.
    send("t6", 4'hA, 0); send("t6", 4'h5, 0);
    do_reset("t6");
    send("t6", 4'h5, 0); send("t6", 4'h6, 0);
    idle("t6", 2, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] v;
      bit r;
      r = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 40) == 0) begin
        idle("rnd", $urandom_range(TMO - 3, TMO + 2), r);
      end else begin
        v = ($urandom_range(0, 3) == 0) ? SYNC : 4'($urandom_range(0, 15));
        step("rnd", ($urandom_range(0, 2) != 0), v, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
